// File: rtl/sudoku_ui_pkg.sv
// Shared definitions for the Sudoku entry user interface.
// Provides the controller state type, default timing constants and the
// wrap-around search for selectable (unlocked) cells.
package sudoku_ui_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NAV  = 2'd1,
    EDIT = 2'd2
  } uiState_t;

  localparam int unsigned DefaultBlinkDiv      = 25000000;
  localparam int unsigned DefaultTimeoutHalves = 20;
  // Widest cell bank the search function supports.
  localparam int unsigned MaxDigits            = 32;

  typedef struct packed {
    logic [31:0] idx;
    logic        found;
  } cellSearch_t;

  // Finds the nearest unlocked cell strictly after pos in the given direction,
  // wrapping modulo n. The last candidate examined is pos itself, so a lone
  // unlocked cursor cell is reported as found at its own index.
  function automatic cellSearch_t next_unlocked(input logic [MaxDigits-1:0] locked,
                                                input int unsigned pos,
                                                input int unsigned n,
                                                input logic up);
    cellSearch_t res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MaxDigits; k++) begin
      if (k <= n && !res.found) begin
        cand = up ? pos + k : pos + n - k;
        if (cand >= n) cand = cand - n;
        if (!locked[cand]) begin
          res.idx   = cand;
          res.found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink half-period divider for the selected digit.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   enable     - count while high; held at zero with phase lit when low
//   restart    - clear the divider and force phase lit on the next cycle
//   half_rate  - use BLINK_DIV/2 cycles per half-period instead of BLINK_DIV
//   phase      - registered blink phase, 1 = lit
//   toggle     - combinational pulse on the cycle whose edge flips phase
module blink_timer #(
  parameter int unsigned BLINK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  input  logic half_rate,
  output logic phase,
  output logic toggle
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] cntQ;
  logic [CntW-1:0] termCnt;

  assign termCnt = half_rate ? CntW'(BLINK_DIV / 2 - 1) : CntW'(BLINK_DIV - 1);
  // Not gated by restart so the controller can use it without a loop;
  // restart still wins inside the divider.
  assign toggle  = enable && (cntQ == termCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntQ  <= '0;
      phase <= 1'b1;
    end else if (!enable || restart) begin
      cntQ  <= '0;
      phase <= 1'b1;
    end else if (cntQ == termCnt) begin
      cntQ  <= '0;
      phase <= ~phase;
    end else begin
      cntQ  <= cntQ + 1'b1;
    end
  end

endmodule

// File: rtl/cursor_select_controller.sv
// Cursor / digit-select sequencer for Sudoku entry on a multi-digit display.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   btn_left/right/enter - one-cycle debounced button pulses
//   cell_locked   - per-cell given flag, locked cells are never selected
//   digit_sel     - one-hot selected digit, zero when idle
//   cursor_pos    - binary cursor index
//   blink_phase   - 1 = selected digit lit
//   edit_mode     - high in EDIT
module cursor_select_controller
  import sudoku_ui_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BLINK_DIV      = DefaultBlinkDiv,
  parameter int unsigned TIMEOUT_HALVES = DefaultTimeoutHalves
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     btn_left,
  input  logic                                     btn_right,
  input  logic                                     btn_enter,
  input  logic [NUM_DIGITS-1:0]                    cell_locked,
  output logic [NUM_DIGITS-1:0]                    digit_sel,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] cursor_pos,
  output logic                                     blink_phase,
  output logic                                     edit_mode
);

  localparam int unsigned CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_HALVES + 1);

  uiState_t        stateQ, stateD;
  logic [CW-1:0]   cursorQ, cursorD;
  logic [TW-1:0]   timeoutQ, timeoutD;
  logic            accepted;
  logic            restart;
  logic            toggle;
  logic [MaxDigits-1:0] lockedExt;
  cellSearch_t     upSel, downSel, firstSel;

  assign lockedExt = MaxDigits'(cell_locked);

  always_comb begin
    upSel    = next_unlocked(lockedExt, 32'(cursorQ), NUM_DIGITS, 1'b1);
    downSel  = next_unlocked(lockedExt, 32'(cursorQ), NUM_DIGITS, 1'b0);
    // Searching upward from the top index yields the lowest unlocked cell.
    firstSel = next_unlocked(lockedExt, NUM_DIGITS - 1, NUM_DIGITS, 1'b1);
  end

  always_comb begin
    stateD   = stateQ;
    cursorD  = cursorQ;
    accepted = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (btn_enter && firstSel.found) begin
          stateD   = NAV;
          cursorD  = CW'(firstSel.idx);
          accepted = 1'b1;
        end
      end
      NAV, EDIT: begin
        if (cell_locked[cursorQ]) begin
          // Cursor cell became a given: relocate, buttons this cycle are dropped.
          if (upSel.found) begin
            stateD  = NAV;
            cursorD = CW'(upSel.idx);
          end else begin
            stateD  = IDLE;
          end
        end else if (btn_enter) begin
          stateD   = (stateQ == NAV) ? EDIT : NAV;
          accepted = 1'b1;
        end else if (stateQ == NAV && btn_right && !btn_left) begin
          cursorD  = CW'(upSel.idx);
          accepted = 1'b1;
        end else if (stateQ == NAV && btn_left && !btn_right) begin
          cursorD  = CW'(downSel.idx);
          accepted = 1'b1;
        end else if (stateQ == NAV && toggle && timeoutQ >= TW'(TIMEOUT_HALVES - 1)) begin
          stateD   = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase

    restart = accepted || (stateD != stateQ) || (cursorD != cursorQ);

    timeoutD = timeoutQ;
    if (restart || stateQ != NAV) begin
      timeoutD = '0;
    end else if (toggle && timeoutQ != TW'(TIMEOUT_HALVES)) begin
      timeoutD = timeoutQ + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= IDLE;
      cursorQ   <= '0;
      timeoutQ  <= '0;
      digit_sel <= '0;
      edit_mode <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cursorQ   <= cursorD;
      timeoutQ  <= timeoutD;
      digit_sel <= (stateD == IDLE) ? '0 : (NUM_DIGITS'(1) << cursorD);
      edit_mode <= (stateD == EDIT);
    end
  end

  assign cursor_pos = cursorQ;

  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (stateQ != IDLE),
    .restart   (restart),
    .half_rate (stateQ == EDIT),
    .phase     (blink_phase),
    .toggle    (toggle)
  );

endmodule

// File: doc/cursor_select_controller.md
Name: cursor_select_controller

Overview:
- Sequences digit selection on the multi-digit seven-segment display for Sudoku entry.
- Owns the cursor position and the NAV/EDIT mode, and skips locked (given) cells.
- Generates the per-digit select vector and blink phase consumed by the per-digit blinker instances.
- Sits between the debounced button pulses and the bank of digit blinkers.

Parameters:
- NUM_DIGITS, 4, number of display digits / selectable cells; CW = $clog2(NUM_DIGITS), min 1.
- BLINK_DIV, 25000000, clk cycles per blink half-period in NAV. EDIT uses BLINK_DIV/2. BLINK_DIV must be even and ≥2.
- TIMEOUT_HALVES, 20, NAV blink half-periods with no accepted button before returning to IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- btn_left  in  1  one-cycle pulse, move cursor left
- btn_right  in  1  one-cycle pulse, move cursor right
- btn_enter  in  1  one-cycle pulse, select / toggle edit
- cell_locked  in  NUM_DIGITS  1 = cell is a given and cannot be selected
- digit_sel  out  NUM_DIGITS  one-hot selected digit; all-zero when IDLE
- cursor_pos  out  CW  binary cursor index
- blink_phase  out  1  1 = selected digit lit, 0 = blanked
- edit_mode  out  1  1 in EDIT state

Behaviour:
- Reset (rst=0, async): state=IDLE, cursor_pos=0, digit_sel=0, blink_phase=1, edit_mode=0, blink counter=0, timeout counter=0.
- All outputs are registered. Effects appear the cycle after the input pulse.
- States:
  - IDLE: digit_sel=0, blink counter held at 0, blink_phase=1.
  - NAV: digit_sel=onehot(cursor_pos); blink_phase toggles every BLINK_DIV cycles.
  - EDIT: same select; toggles every BLINK_DIV/2 cycles; edit_mode=1.
- IDLE + enter: if any cell is unlocked, go to NAV with cursor at the lowest unlocked index. If all cells are locked, stay in IDLE.
- NAV + right: cursor moves to the next unlocked index above the current one, wrapping modulo NUM_DIGITS. If no other cell is unlocked, the cursor stays put. Left is the same search descending, with wrap.
- NAV + enter: go to EDIT; cursor unchanged.
- EDIT + enter: go to NAV. Left/right are ignored in EDIT.
- Button priority per cycle:
  - left and right together: both ignored.
  - enter with left or right: enter wins, moves are ignored.
- Restart rule: any accepted move or state change clears the blink counter and sets blink_phase=1 the next cycle, so the selected digit is visible immediately.
- Timeout:
  - Counts blink-phase toggles in NAV only.
  - Cleared on any accepted button and on entry to NAV.
  - Reaching TIMEOUT_HALVES: go to IDLE, cursor_pos retained.
  - EDIT never times out.
- Lock change: if cell_locked[cursor_pos]=1 while in NAV or EDIT, the next cycle moves the cursor to the next unlocked index ascending with wrap, and EDIT drops to NAV. If none is unlocked, go to IDLE. A button pulse in the same cycle is ignored.
- Counter widths: blink counter is $clog2(BLINK_DIV) bits and wraps to 0 at terminal count; the timeout counter saturates.
- Reset mid-operation returns immediately to the reset values; no pending moves are kept.

Decomposition:
- Shared package sudoku_ui_pkg:
  - state enum {IDLE, NAV, EDIT}.
  - Default BLINK_DIV and TIMEOUT_HALVES constants.
  - Function next_unlocked(locked, pos, dir) returning the index and a found flag.
- One sub-module blink_timer:
  - Inputs: enable, restart, half_rate.
  - Outputs: phase and a toggle pulse.
  - Reuses the divider style of the existing one-second timer.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4, TIMEOUT_HALVES=3):
- Reset, then enter with cell_locked=4'b0001 -> next cycle NAV, cursor_pos=1, digit_sel=4'b0010, blink_phase=1; phase toggles every 4 cycles.
- From cursor 3 with locked=4'b0000, right -> cursor 0 (wrap); left then gives 3. Locked=4'b1011, right from 2 -> stays 2.
- NAV, enter -> edit_mode=1, phase toggles every 2 cycles. Left ignored. Enter again -> NAV, blink restarts with phase=1.
- NAV, no buttons for 12 cycles -> IDLE, digit_sel=0, cursor_pos retained. EDIT held for 40 cycles -> stays EDIT.
- In EDIT at cursor 2, set locked=4'b0100 -> next cycle NAV, cursor 3. Then set locked=4'b1111 -> IDLE.
- Same-cycle left+right -> no change. Enter+right in NAV -> EDIT, cursor unchanged. rst asserted mid-blink -> all outputs at reset values without waiting for a clk edge.
